// File: rtl/reg_file_seq.sv
// Initiator-side sequencer for the 4-entry register file.
// Accepts one operation per handshake, walks the register-file read latency
// for its sources, computes the result and writes it back to the destination.
module reg_file_seq #(
  parameter int WIDTH = 9,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [2:0]       in_src1,
  input  logic [2:0]       in_src2,
  input  logic [2:0]       in_dst,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] reg_val,
  output logic [2:0]       reg_sel,
  output logic [2:0]       reg_num,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP1, S_CAP2, S_EXEC, S_WB, S_ERR
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MOV = 2'd2;
  localparam logic [1:0] OP_LDI = 2'd3;

  state_t           state, state_nx;
  logic [1:0]       op_q;
  logic [2:0]       src1_q, src2_q, dst_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic [WIDTH:0]   alu_out;

  // A register index is addressable only in 1..NREG; 0 means "no access".
  function automatic logic idx_ok(input logic [2:0] idx);
    return (idx != 3'd0) && (int'(idx) <= NREG);
  endfunction

  // One extra bit holds the ADD carry-out or, for SUB, the borrow.
  function automatic logic [WIDTH:0] alu(input logic [1:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    if (op == OP_SUB) return {1'b0, a} - {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign alu_out = alu(op_q, opa, opb);
  assign result  = result_q;
  assign ovf     = ovf_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Capture the operation fields at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
      imm_q  <= '0;
    end else if (state == S_IDLE && in_valid) begin
      op_q   <= in_opcode;
      src1_q <= in_src1;
      src2_q <= in_src2;
      dst_q  <= in_dst;
      imm_q  <= in_imm;
    end
  end

  // Capture operands one cycle after their read select was presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
    end else begin
      case (state)
        S_RD_B, S_CAP1: opa <= reg_val;
        S_CAP2:         opb <= reg_val;
        default: ;
      endcase
    end
  end

  // Compute in EXEC, publish the held result at the end of WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_next <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == S_EXEC) begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            res_next <= alu_out[WIDTH-1:0];
            ovf_q    <= alu_out[WIDTH];
          end
          OP_MOV:  res_next <= opa;
          default: res_next <= imm_q;
        endcase
      end
      if (state == S_WB) result_q <= res_next;
    end
  end

  // Next-state logic and register-file port decode.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    reg_sel  = 3'd0;
    reg_num  = 3'd0;
    op1      = '0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!idx_ok(in_dst))                                   state_nx = S_ERR;
          else if (in_opcode != OP_LDI && !idx_ok(in_src1))      state_nx = S_ERR;
          else if ((in_opcode == OP_ADD || in_opcode == OP_SUB) &&
                   !idx_ok(in_src2))                              state_nx = S_ERR;
          else if (in_opcode == OP_LDI)                           state_nx = S_EXEC;
          else                                                    state_nx = S_RD_A;
        end
      end
      S_RD_A: begin
        reg_sel  = src1_q;
        state_nx = (op_q == OP_MOV) ? S_CAP1 : S_RD_B;
      end
      S_RD_B: begin
        reg_sel  = src2_q;
        state_nx = S_CAP2;
      end
      S_CAP1:  state_nx = S_EXEC;
      S_CAP2:  state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB: begin
        reg_num  = dst_q;
        op1      = res_next;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
